ab_seq_gen: RTL and testbench

AB_SEQ_GEN -- requirements
Module: ab_seq_gen

---
 rtl/ab_seq_gen_pkg.sv | 58 +++++
 rtl/ab_seq_gen_lfsr8.sv | 34 +++
 rtl/ab_seq_gen.sv | 142 ++++++++++++++
 tb/tb_ab_seq_gen.sv | 312 +++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/ab_seq_gen_pkg.sv
// Shared definitions for the a/b protocol: state encodings, the legal edge
// table and the per-state illegal pair used for fault injection.
package ab_seq_gen_pkg;

    typedef enum logic [2:0] {
        S0 = 3'd0,
        S1 = 3'd1,
        S2 = 3'd2,
        S3 = 3'd3,
        S4 = 3'd4,
        S5 = 3'd5
    } pstate_e;

    typedef enum logic {
        IDLE = 1'b0,
        RUN  = 1'b1
    } ctrl_e;

    localparam logic [7:0] LFSR_RESET = 8'h01;

    // Pair {a,b} emitted when leaving state s through option opt.
    function automatic logic [1:0] edge_pair(input pstate_e s, input logic opt);
        case (s)
            S0:      edge_pair = opt ? 2'b00 : 2'b11;
            S1:      edge_pair = opt ? 2'b01 : 2'b10;
            S2:      edge_pair = opt ? 2'b10 : 2'b00;
            S3:      edge_pair = opt ? 2'b10 : 2'b00;
            S4:      edge_pair = opt ? 2'b10 : 2'b01;
            S5:      edge_pair = opt ? 2'b10 : 2'b00;
            default: edge_pair = 2'b00;
        endcase
    endfunction

    function automatic pstate_e edge_next(input pstate_e s, input logic opt);
        case (s)
            S0:      edge_next = opt ? S5 : S1;
            S1:      edge_next = opt ? S3 : S4;
            S2:      edge_next = opt ? S5 : S1;
            S3:      edge_next = opt ? S4 : S2;
            S4:      edge_next = opt ? S3 : S5;
            S5:      edge_next = opt ? S0 : S5;
            default: edge_next = S0;
        endcase
    endfunction

    function automatic logic [1:0] illegal_pair(input pstate_e s);
        case (s)
            S0:      illegal_pair = 2'b10;
            S1:      illegal_pair = 2'b00;
            S2:      illegal_pair = 2'b01;
            S3:      illegal_pair = 2'b11;
            S4:      illegal_pair = 2'b00;
            S5:      illegal_pair = 2'b01;
            default: illegal_pair = 2'b00;
        endcase
    endfunction

endpackage

// File: rtl/ab_seq_gen_lfsr8.sv
// 8-bit Galois LFSR; a load combined with a shift loads the already-stepped
// seed so the very first beat of a burst also advances the sequence.
module ab_lfsr8
    import ab_seq_gen_pkg::*;
#(
    parameter logic [7:0] TAPS = 8'hB8
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       load,
    input  logic [7:0] seed,
    input  logic       shift,
    output logic [7:0] q
);

    logic [7:0] seed_eff;
    logic [7:0] base;
    logic [7:0] stepped;

    always_comb begin
        seed_eff = (seed == 8'h00) ? LFSR_RESET : seed;
        base     = load ? seed_eff : q;
        stepped  = base[0] ? ((base >> 1) ^ TAPS) : (base >> 1);
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            q <= LFSR_RESET;
        end else if (load || shift) begin
            q <= shift ? stepped : base;
        end
    end

endmodule

// File: rtl/ab_seq_gen.sv
// Burst generator for the a/b protocol: walks the legal edge graph with a
// valid/ready handshake, optionally inserting one illegal pair on request.
module ab_seq_gen #(
    parameter int         LEN_W     = 8,
    parameter logic [7:0] LFSR_TAPS = 8'hB8
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             start,
    input  logic [LEN_W-1:0] len,
    input  logic [7:0]       seed,
    input  logic             mode,
    input  logic             sel,
    input  logic             inject,
    input  logic             ready,
    output logic             a,
    output logic             b,
    output logic             valid,
    output logic             illegal,
    output logic             busy,
    output logic             done,
    output logic [2:0]       pstate
);
    import ab_seq_gen_pkg::*;

    ctrl_e            state_reg;
    pstate_e          pstate_reg;
    logic [LEN_W-1:0] len_reg;
    logic [LEN_W-1:0] beat_cnt_reg;
    logic             mode_reg;
    logic             cur_opt_reg;
    logic             inject_pending_reg;
    logic             a_reg, b_reg, valid_reg, illegal_reg, busy_reg, done_reg;

    logic [7:0]       lfsr_q;
    logic             lfsr_unused;
    logic             start_go, load_first, load_next, load_beat, accept, last_beat;
    logic             mode_eff, lfsr_bit, choice, inj_eff;
    logic [LEN_W-1:0] cnt_inc;
    pstate_e          pstate_adv, base_state;
    logic [1:0]       new_pair;

    assign lfsr_unused = ^lfsr_q[7:1];

    always_comb begin
        start_go   = (state_reg == IDLE) && start;
        load_first = start_go && (len != '0);
        accept     = (state_reg == RUN) && valid_reg && ready;
        cnt_inc    = beat_cnt_reg + LEN_W'(1);
        last_beat  = (cnt_inc == len_reg);
        load_next  = accept && !last_beat;
        load_beat  = load_first || load_next;
        // In IDLE the beat is built from the inputs being captured this cycle.
        mode_eff   = (state_reg == IDLE) ? mode : mode_reg;
        lfsr_bit   = (state_reg == IDLE) ? ((seed == 8'h00) || seed[0]) : lfsr_q[0];
        choice     = mode_eff ? sel : lfsr_bit;
        pstate_adv = illegal_reg ? pstate_reg : edge_next(pstate_reg, cur_opt_reg);
        base_state = (state_reg == IDLE) ? pstate_reg : pstate_adv;
        inj_eff    = inject || inject_pending_reg;
        new_pair   = inj_eff ? illegal_pair(base_state) : edge_pair(base_state, choice);
    end

    ab_lfsr8 #(
        .TAPS (LFSR_TAPS)
    ) u_lfsr (
        .clk   (clk),
        .reset (reset),
        .load  (start_go),
        .seed  (seed),
        .shift (load_beat && !mode_eff),
        .q     (lfsr_q)
    );

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_reg          <= IDLE;
            pstate_reg         <= S0;
            len_reg            <= '0;
            beat_cnt_reg       <= '0;
            mode_reg           <= 1'b0;
            cur_opt_reg        <= 1'b0;
            inject_pending_reg <= 1'b0;
            a_reg              <= 1'b0;
            b_reg              <= 1'b0;
            valid_reg          <= 1'b0;
            illegal_reg        <= 1'b0;
            busy_reg           <= 1'b0;
            done_reg           <= 1'b0;
        end else begin
            done_reg <= 1'b0;
            if (accept) begin
                pstate_reg   <= pstate_adv;
                beat_cnt_reg <= cnt_inc;
            end
            if (load_beat) begin
                {a_reg, b_reg}     <= new_pair;
                valid_reg          <= 1'b1;
                illegal_reg        <= inj_eff;
                cur_opt_reg        <= choice;
                inject_pending_reg <= 1'b0;
            end else if (inject) begin
                inject_pending_reg <= 1'b1;
            end
            case (state_reg)
                IDLE: begin
                    if (start_go) begin
                        if (len == '0) begin
                            done_reg <= 1'b1;
                        end else begin
                            state_reg    <= RUN;
                            busy_reg     <= 1'b1;
                            len_reg      <= len;
                            mode_reg     <= mode;
                            beat_cnt_reg <= '0;
                        end
                    end
                end
                RUN: begin
                    if (accept && last_beat) begin
                        state_reg   <= IDLE;
                        busy_reg    <= 1'b0;
                        done_reg    <= 1'b1;
                        valid_reg   <= 1'b0;
                        illegal_reg <= 1'b0;
                        a_reg       <= 1'b0;
                        b_reg       <= 1'b0;
                    end
                end
                default: state_reg <= IDLE;
            endcase
        end
    end

    assign a       = a_reg;
    assign b       = b_reg;
    assign valid   = valid_reg;
    assign illegal = illegal_reg;
    assign busy    = busy_reg;
    assign done    = done_reg;
    assign pstate  = pstate_reg;

endmodule

// File: tb/tb_ab_seq_gen.sv
// Directed bench for ab_seq_gen: hand-computed beat sequences per scenario.
module tb_ab_seq_gen;

    logic       clk = 1'b0;
    logic       reset = 1'b0;
    logic       start = 1'b0;
    logic [7:0] len = 8'd0;
    logic [7:0] seed = 8'd0;
    logic       mode = 1'b0;
    logic       sel = 1'b0;
    logic       inject = 1'b0;
    logic       ready = 1'b1;
    logic       a, b, valid, illegal, busy, done;
    logic [2:0] pstate;

    int total = 0;
    int bad = 0;

    logic [1:0] acc_ab [64];
    logic       acc_ill[64];
    logic [1:0] tr_ab  [64];
    logic       tr_v   [64];
    logic [1:0] seq1   [64];
    int         acc_n, done_n, valid_n;

    ab_seq_gen dut (
        .clk     (clk),
        .reset   (reset),
        .start   (start),
        .len     (len),
        .seed    (seed),
        .mode    (mode),
        .sel     (sel),
        .inject  (inject),
        .ready   (ready),
        .a       (a),
        .b       (b),
        .valid   (valid),
        .illegal (illegal),
        .busy    (busy),
        .done    (done),
        .pstate  (pstate)
    );

    always #5 clk = ~clk;

    // Independent model of the protocol graph: next state, or -1 if not an edge.
    function automatic int bench_edge(input int st, input logic [1:0] ab);
        case (st)
            0: return (ab == 2'b11) ? 1 : (ab == 2'b00) ? 5 : -1;
            1: return (ab == 2'b10) ? 4 : (ab == 2'b01) ? 3 : -1;
            2: return (ab == 2'b00) ? 1 : (ab == 2'b10) ? 5 : -1;
            3: return (ab == 2'b00) ? 2 : (ab == 2'b10) ? 4 : -1;
            4: return (ab == 2'b01) ? 5 : (ab == 2'b10) ? 3 : -1;
            5: return (ab == 2'b00) ? 5 : (ab == 2'b10) ? 0 : -1;
            default: return -1;
        endcase
    endfunction

    task automatic do_reset();
        @(negedge clk);
        reset = 1'b1;
        start = 1'b0;
        inject = 1'b0;
        ready = 1'b1;
        @(negedge clk);
        @(negedge clk);
        reset = 1'b0;
    endtask

    // Issue one burst and trace it for ncyc cycles; ready is low for three
    // cycles starting at trace index stall_at (negative: no stall).
    task automatic run_burst(input int l, input logic [7:0] s, input logic m,
                             input logic sl, input logic inj, input int stall_at,
                             input int ncyc);
        @(negedge clk);
        start = 1'b1; len = 8'(l); seed = s; mode = m; sel = sl; inject = inj; ready = 1'b1;
        @(negedge clk);
        start = 1'b0; inject = 1'b0;
        acc_n = 0; done_n = 0; valid_n = 0;
        for (int i = 0; i < ncyc; i++) begin
            if (i > 0) @(negedge clk);
            tr_ab[i] = {a, b};
            tr_v[i]  = valid;
            if (valid) valid_n++;
            if (done) done_n++;
            ready = !(stall_at >= 0 && i >= stall_at && i < stall_at + 3);
            if (valid && ready && acc_n < 64) begin
                acc_ab[acc_n]  = {a, b};
                acc_ill[acc_n] = illegal;
                acc_n++;
            end
        end
        ready = 1'b1;
    endtask

    task automatic test_reset();
        do_reset();
        total++;
        if ({a, b, valid, illegal, busy, done} !== 6'b0 || pstate !== 3'd0) begin
            bad++;
            $display("FAIL reset_state: got ab=%b%b v=%b ill=%b busy=%b done=%b ps=%0d want all 0",
                     a, b, valid, illegal, busy, done, pstate);
        end
        $display("reset: ps=%0d valid=%b", pstate, valid);
    endtask

    task automatic test_mode1_sel0();
        logic [1:0] exp_ab[4] = '{2'b11, 2'b10, 2'b01, 2'b00};
        do_reset();
        @(negedge clk);
        start = 1'b1; len = 8'd4; mode = 1'b1; sel = 1'b0;
        @(negedge clk);
        start = 1'b0;
        total++;
        if (busy !== 1'b1 || valid !== 1'b1) begin
            bad++;
            $display("FAIL sel0_first_load: got busy=%b valid=%b want 1 1", busy, valid);
        end
        do_reset();
        run_burst(4, 8'h00, 1'b1, 1'b0, 1'b0, -1, 10);
        for (int i = 0; i < 4; i++) begin
            total++;
            if (acc_ab[i] !== exp_ab[i]) begin
                bad++;
                $display("FAIL sel0_beat%0d: got %b want %b", i, acc_ab[i], exp_ab[i]);
            end
        end
        total++;
        if (pstate !== 3'd5 || done_n != 1 || valid_n != 4 || acc_n != 4 || busy !== 1'b0) begin
            bad++;
            $display("FAIL sel0_end: got ps=%0d done=%0d valid_cyc=%0d beats=%0d busy=%b want 5 1 4 4 0",
                     pstate, done_n, valid_n, acc_n, busy);
        end
        $display("mode1_sel0: beats=%0d ps=%0d done=%0d", acc_n, pstate, done_n);
    endtask

    task automatic test_mode1_sel1();
        logic [1:0] exp_ab[3] = '{2'b00, 2'b10, 2'b00};
        do_reset();
        run_burst(3, 8'h00, 1'b1, 1'b1, 1'b0, -1, 9);
        for (int i = 0; i < 3; i++) begin
            total++;
            if (acc_ab[i] !== exp_ab[i]) begin
                bad++;
                $display("FAIL sel1_beat%0d: got %b want %b", i, acc_ab[i], exp_ab[i]);
            end
        end
        total++;
        if (pstate !== 3'd5 || acc_n != 3) begin
            bad++;
            $display("FAIL sel1_end: got ps=%0d beats=%0d want 5 3", pstate, acc_n);
        end
        $display("mode1_sel1: beats=%0d ps=%0d", acc_n, pstate);
    endtask

    task automatic test_inject();
        logic [1:0] exp_ab [3] = '{2'b10, 2'b11, 2'b10};
        logic       exp_ill[3] = '{1'b1, 1'b0, 1'b0};
        do_reset();
        run_burst(3, 8'h00, 1'b1, 1'b0, 1'b1, -1, 9);
        for (int i = 0; i < 3; i++) begin
            total++;
            if (acc_ab[i] !== exp_ab[i] || acc_ill[i] !== exp_ill[i]) begin
                bad++;
                $display("FAIL inject_beat%0d: got %b ill=%b want %b ill=%b",
                         i, acc_ab[i], acc_ill[i], exp_ab[i], exp_ill[i]);
            end
        end
        total++;
        if (pstate !== 3'd4) begin
            bad++;
            $display("FAIL inject_end: got ps=%0d want 4", pstate);
        end
        // A pulse while idle stays pending until the next burst loads a beat.
        do_reset();
        @(negedge clk); inject = 1'b1;
        @(negedge clk); inject = 1'b0;
        @(negedge clk);
        run_burst(2, 8'h00, 1'b1, 1'b0, 1'b0, -1, 8);
        total++;
        if (acc_n != 2 || acc_ab[0] !== 2'b10 || acc_ill[0] !== 1'b1 ||
            acc_ab[1] !== 2'b11 || acc_ill[1] !== 1'b0 || pstate !== 3'd1) begin
            bad++;
            $display("FAIL inject_pending: got n=%0d %b/%b %b/%b ps=%0d want 2 10/1 11/0 ps=1",
                     acc_n, acc_ab[0], acc_ill[0], acc_ab[1], acc_ill[1], pstate);
        end
        $display("inject: ps=%0d", pstate);
    endtask

    task automatic test_backpressure();
        logic [1:0] exp_ab[4] = '{2'b11, 2'b10, 2'b01, 2'b00};
        do_reset();
        run_burst(4, 8'h00, 1'b1, 1'b0, 1'b0, 1, 13);
        for (int i = 2; i <= 4; i++) begin
            total++;
            if (tr_v[i] !== 1'b1 || tr_ab[i] !== tr_ab[1]) begin
                bad++;
                $display("FAIL stall_hold%0d: got v=%b ab=%b want v=1 ab=%b", i, tr_v[i], tr_ab[i], tr_ab[1]);
            end
        end
        total++;
        if (acc_n != 4 || acc_ab[0] !== exp_ab[0] || acc_ab[1] !== exp_ab[1] ||
            acc_ab[2] !== exp_ab[2] || acc_ab[3] !== exp_ab[3] || done_n != 1) begin
            bad++;
            $display("FAIL stall_beats: got n=%0d %b %b %b %b done=%0d want 4 11 10 01 00 done=1",
                     acc_n, acc_ab[0], acc_ab[1], acc_ab[2], acc_ab[3], done_n);
        end
        $display("backpressure: beats=%0d valid_cyc=%0d", acc_n, valid_n);
    endtask

    task automatic test_lfsr_repeat();
        int st;
        int nx;
        int nbad;
        do_reset();
        run_burst(20, 8'h5A, 1'b0, 1'b0, 1'b0, -1, 26);
        for (int i = 0; i < 20; i++) seq1[i] = acc_ab[i];
        st = 0;
        nbad = 0;
        for (int i = 0; i < acc_n; i++) begin
            nx = bench_edge(st, acc_ab[i]);
            if (nx < 0 || acc_ill[i] !== 1'b0) nbad++;
            else st = nx;
        end
        total++;
        if (acc_n != 20 || nbad != 0 || pstate !== 3'(st)) begin
            bad++;
            $display("FAIL lfsr_legal: got beats=%0d errs=%0d ps=%0d want 20 0 ps=%0d",
                     acc_n, nbad, pstate, st);
        end
        do_reset();
        run_burst(20, 8'h5A, 1'b0, 1'b0, 1'b0, -1, 26);
        nbad = 0;
        for (int i = 0; i < 20; i++) if (acc_ab[i] !== seq1[i]) nbad++;
        total++;
        if (acc_n != 20 || nbad != 0) begin
            bad++;
            $display("FAIL lfsr_repeat: got beats=%0d diffs=%0d want 20 0", acc_n, nbad);
        end
        $display("lfsr_repeat: beats=%0d end_ps=%0d", acc_n, pstate);
    endtask

    task automatic test_reset_midburst();
        int done_seen;
        do_reset();
        @(negedge clk);
        start = 1'b1; len = 8'd10; mode = 1'b1; sel = 1'b0; ready = 1'b1;
        @(negedge clk);
        start = 1'b0;
        @(negedge clk);
        total++;
        if (valid !== 1'b1 || {a, b} !== 2'b10) begin
            bad++;
            $display("FAIL mid_beat2: got v=%b ab=%b%b want 1 10", valid, a, b);
        end
        reset = 1'b1;
        #1;
        total++;
        if ({a, b, valid, illegal, busy, done} !== 6'b0 || pstate !== 3'd0) begin
            bad++;
            $display("FAIL mid_reset: got ab=%b%b v=%b ill=%b busy=%b done=%b ps=%0d want all 0",
                     a, b, valid, illegal, busy, done, pstate);
        end
        @(negedge clk);
        reset = 1'b0;
        done_seen = 0;
        for (int i = 0; i < 5; i++) begin
            @(negedge clk);
            if (done || valid) done_seen++;
        end
        total++;
        if (done_seen != 0) begin
            bad++;
            $display("FAIL mid_no_done: got %0d active cycles want 0", done_seen);
        end
        $display("reset_midburst: ps=%0d", pstate);
    endtask

    task automatic test_len_zero();
        @(negedge clk);
        start = 1'b1; len = 8'd0;
        @(negedge clk);
        start = 1'b0;
        total++;
        if (done !== 1'b1 || valid !== 1'b0 || busy !== 1'b0) begin
            bad++;
            $display("FAIL len0_done: got done=%b valid=%b busy=%b want 1 0 0", done, valid, busy);
        end
        @(negedge clk);
        total++;
        if (done !== 1'b0 || valid !== 1'b0) begin
            bad++;
            $display("FAIL len0_pulse: got done=%b valid=%b want 0 0", done, valid);
        end
        $display("len_zero: done pulse checked");
    endtask

    initial begin
        test_reset();
        test_mode1_sel0();
        test_mode1_sel1();
        test_inject();
        test_backpressure();
        test_lfsr_repeat();
        test_reset_midburst();
        test_len_zero();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
